// File: rtl/roce_qp_context_table.sv
// roce_qp_context_table
// Per-queue-pair context store. The control plane opens and modifies entries,
// the TX header path advances the remote PSN, and the work queue looks up
// entries with a registered one-cycle response. Local QPNs are 0x100 + index.
//
// state    | meaning
// ---------+--------------------------------------------
// RESET    | entry unused, PSNs cleared
// INIT     | opened, keys and addresses programmed
// RTR      | ready to receive
// RTS      | ready to send, PSN advance permitted
// SQ_DRAIN | send queue draining
// SQ_ERROR | send queue error
// ERROR    | queue pair in error

module roce_qp_context_table #(
    parameter int MAX_QUEUE_PAIRS = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_qp_context_req,
    input  logic [23:0] s_qp_local_qpn_req,
    output logic        m_qp_context_valid,
    output logic [2:0]  m_qp_state,
    output logic [31:0] m_qp_r_key,
    output logic [23:0] m_qp_rem_qpn,
    output logic [23:0] m_qp_loc_qpn,
    output logic [23:0] m_qp_rem_psn,
    output logic [23:0] m_qp_loc_psn,
    output logic [31:0] m_qp_rem_ip_addr,
    output logic [63:0] m_qp_rem_addr,

    input  logic        s_open_valid,
    output logic        s_open_ready,
    input  logic [23:0] s_open_loc_qpn,
    input  logic [23:0] s_open_rem_qpn,
    input  logic [23:0] s_open_rem_psn,
    input  logic [23:0] s_open_loc_psn,
    input  logic [31:0] s_open_r_key,
    input  logic [31:0] s_open_rem_ip_addr,
    input  logic [63:0] s_open_rem_addr,

    input  logic        s_mod_valid,
    output logic        s_mod_ready,
    input  logic [23:0] s_mod_qpn,
    input  logic [2:0]  s_mod_state,
    output logic        m_mod_status_valid,
    output logic        m_mod_status_err,

    input  logic        s_psn_adv_valid,
    output logic        s_psn_adv_ready,
    input  logic [23:0] s_psn_adv_qpn,
    input  logic [23:0] s_psn_adv_count
);

    localparam int IW = (MAX_QUEUE_PAIRS > 1) ? $clog2(MAX_QUEUE_PAIRS) : 1;

    localparam logic [2:0] ST_RESET    = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_RTR      = 3'd2;
    localparam logic [2:0] ST_RTS      = 3'd3;
    localparam logic [2:0] ST_SQ_DRAIN = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd6;

    // Entry storage, one array per field
    logic [2:0]  mem_state    [MAX_QUEUE_PAIRS];
    logic [31:0] mem_r_key    [MAX_QUEUE_PAIRS];
    logic [23:0] mem_rem_qpn  [MAX_QUEUE_PAIRS];
    logic [23:0] mem_loc_qpn  [MAX_QUEUE_PAIRS];
    logic [23:0] mem_rem_psn  [MAX_QUEUE_PAIRS];
    logic [23:0] mem_loc_psn  [MAX_QUEUE_PAIRS];
    logic [31:0] mem_rem_ip   [MAX_QUEUE_PAIRS];
    logic [63:0] mem_rem_addr [MAX_QUEUE_PAIRS];

    logic [IW-1:0] open_idx;
    logic [IW-1:0] mod_idx;
    logic [IW-1:0] psn_idx;
    logic [IW-1:0] lk_idx;
    logic          open_hit;
    logic          mod_take;
    logic          mod_legal;
    logic          mod_commit;
    logic          psn_take;
    logic          psn_commit;
    logic          lk_ok;
    logic [2:0]    mod_cur_state;
    logic [2:0]    psn_cur_state;

    // A QPN addresses an entry only inside the 0x100 + index window
    function automatic logic qpn_ok(input logic [23:0] q);
        return (q[23:8] == 16'h0001) && ({24'd0, q[7:0]} < 32'(MAX_QUEUE_PAIRS));
    endfunction

    function automatic logic transition_legal(input logic [2:0] cur, input logic [2:0] tgt);
        logic ok;
        ok = (tgt == cur) || (tgt == ST_RESET) || (tgt == ST_ERROR);
        ok = ok || (cur == ST_RESET    && tgt == ST_INIT);
        ok = ok || (cur == ST_INIT     && tgt == ST_RTR);
        ok = ok || (cur == ST_RTR      && tgt == ST_RTS);
        ok = ok || (cur == ST_RTS      && tgt == ST_SQ_DRAIN);
        ok = ok || (cur == ST_SQ_DRAIN && tgt == ST_RTS);
        return ok;
    endfunction

    // One writer per cycle: open blocks modify, open or modify block PSN advance
    assign s_open_ready    = 1'b1;
    assign s_mod_ready     = !s_open_valid;
    assign s_psn_adv_ready = !s_open_valid && !s_mod_valid;

    assign open_idx = s_open_loc_qpn[IW-1:0];
    assign mod_idx  = s_mod_qpn[IW-1:0];
    assign psn_idx  = s_psn_adv_qpn[IW-1:0];
    assign lk_idx   = s_qp_local_qpn_req[IW-1:0];

    assign mod_cur_state = mem_state[mod_idx];
    assign psn_cur_state = mem_state[psn_idx];

    // Write-port decode for the three control sources
    always_comb begin
        open_hit   = s_open_valid && qpn_ok(s_open_loc_qpn);
        mod_take   = s_mod_valid && s_mod_ready;
        mod_legal  = qpn_ok(s_mod_qpn) && transition_legal(mod_cur_state, s_mod_state);
        mod_commit = mod_take && mod_legal;
        psn_take   = s_psn_adv_valid && s_psn_adv_ready;
        psn_commit = psn_take && qpn_ok(s_psn_adv_qpn) && (psn_cur_state == ST_RTS);
        lk_ok      = qpn_ok(s_qp_local_qpn_req);
    end

    // Context storage update: open overwrites, modify moves state, adv bumps rem_psn
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
                mem_state[i]    <= ST_RESET;
                mem_r_key[i]    <= '0;
                mem_rem_qpn[i]  <= '0;
                mem_loc_qpn[i]  <= '0;
                mem_rem_psn[i]  <= '0;
                mem_loc_psn[i]  <= '0;
                mem_rem_ip[i]   <= '0;
                mem_rem_addr[i] <= '0;
            end
        end else if (open_hit) begin
            mem_state[open_idx]    <= ST_INIT;
            mem_r_key[open_idx]    <= s_open_r_key;
            mem_rem_qpn[open_idx]  <= s_open_rem_qpn;
            mem_loc_qpn[open_idx]  <= s_open_loc_qpn;
            mem_rem_psn[open_idx]  <= s_open_rem_psn;
            mem_loc_psn[open_idx]  <= s_open_loc_psn;
            mem_rem_ip[open_idx]   <= s_open_rem_ip_addr;
            mem_rem_addr[open_idx] <= s_open_rem_addr;
        end else if (mod_commit) begin
            mem_state[mod_idx] <= s_mod_state;
            if (s_mod_state == ST_RESET) begin
                mem_rem_psn[mod_idx] <= '0;
                mem_loc_psn[mod_idx] <= '0;
            end
        end else if (psn_commit) begin
            mem_rem_psn[psn_idx] <= mem_rem_psn[psn_idx] + s_psn_adv_count;
        end
    end

    // Registered lookup response; reads pre-write storage, fields hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            m_qp_context_valid <= 1'b0;
            m_qp_state         <= ST_RESET;
            m_qp_r_key         <= '0;
            m_qp_rem_qpn       <= '0;
            m_qp_loc_qpn       <= '0;
            m_qp_rem_psn       <= '0;
            m_qp_loc_psn       <= '0;
            m_qp_rem_ip_addr   <= '0;
            m_qp_rem_addr      <= '0;
        end else begin
            m_qp_context_valid <= s_qp_context_req;
            if (s_qp_context_req) begin
                if (lk_ok) begin
                    m_qp_state       <= mem_state[lk_idx];
                    m_qp_r_key       <= mem_r_key[lk_idx];
                    m_qp_rem_qpn     <= mem_rem_qpn[lk_idx];
                    m_qp_loc_qpn     <= mem_loc_qpn[lk_idx];
                    m_qp_rem_psn     <= mem_rem_psn[lk_idx];
                    m_qp_loc_psn     <= mem_loc_psn[lk_idx];
                    m_qp_rem_ip_addr <= mem_rem_ip[lk_idx];
                    m_qp_rem_addr    <= mem_rem_addr[lk_idx];
                end else begin
                    m_qp_state       <= ST_RESET;
                    m_qp_r_key       <= '0;
                    m_qp_rem_qpn     <= '0;
                    m_qp_loc_qpn     <= '0;
                    m_qp_rem_psn     <= '0;
                    m_qp_loc_psn     <= '0;
                    m_qp_rem_ip_addr <= '0;
                    m_qp_rem_addr    <= '0;
                end
            end
        end
    end

    // Modify result strobe one cycle after acceptance; err holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            m_mod_status_valid <= 1'b0;
            m_mod_status_err   <= 1'b0;
        end else begin
            m_mod_status_valid <= mod_take;
            if (mod_take) begin
                m_mod_status_err <= !mod_legal;
            end
        end
    end

endmodule
